key_schedule_4bit: RTL and testbench

- Round-key generator sitting directly upstream of the 4-bit key-addition stage; drives its 4-bit key operand one round at a time.
- Holds a KEY_W-bit key state seeded from the master key, and updates it per round in PRESENT style: rotate, S-box the top nibble, then inject the round counter.
- Emits NUM_ROUNDS+1 round keys, the first being whitening, over a valid/ready handshake so the datapath can stall it.
- Top nibble of the key state is the round key; it is a fault-injection target in the stuck-at key case study.

---
 rtl/key_schedule_4bit_pkg.sv | 22 ++
 rtl/sbox_4bit.sv | 11 +
 rtl/key_schedule_4bit.sv | 110 +++++++++++
 tb/tb_key_schedule_4bit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/key_schedule_4bit_pkg.sv
// Shared definitions for the PRESENT-style round-key generator:
// S-box table, FSM states, rotation amount and index-width helper.
package key_schedule_4bit_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int ROT_AMT = 3;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  // Width needed to hold round indices 0..num_rounds.
  function automatic int idx_width(input int num_rounds);
    return (num_rounds < 1) ? 1 : $clog2(num_rounds + 1);
  endfunction

endpackage

// File: rtl/sbox_4bit.sv
// PRESENT 4-bit S-box, purely combinational; shared with the datapath S-box layer.
module sbox_4bit
  import key_schedule_4bit_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = SBOX[din];

endmodule

// File: rtl/key_schedule_4bit.sv
// Round-key generator: seeds a KEY_W-bit state from the master key and emits
// NUM_ROUNDS+1 round keys (top nibble of the state) over a valid/ready handshake.
module key_schedule_4bit
  import key_schedule_4bit_pkg::*;
#(
  parameter int KEY_W      = 16,
  parameter int NUM_ROUNDS = 15
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 io_start,
  input  logic                                 io_clear,
  input  logic [KEY_W-1:0]                     io_master_key,
  output logic [3:0]                           io_round_key,
  output logic                                 io_rk_valid,
  input  logic                                 io_rk_ready,
  output logic [idx_width(NUM_ROUNDS)-1:0]     io_round_idx,
  output logic                                 io_busy,
  output logic                                 io_done
);

  localparam int                IDX_W    = idx_width(NUM_ROUNDS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_ROUNDS);

  state_t            state, state_n;
  logic [KEY_W-1:0]  key_reg, key_n, key_rot, key_upd;
  logic [IDX_W-1:0]  idx, idx_n, idx_inc;
  logic              valid_reg, busy_reg, done_reg, done_n;
  logic [3:0]        sbox_out, rc;
  logic              accept;

  // Update F(K, i): rotate left, S-box the top nibble, xor counter into the low nibble.
  assign key_rot = {key_reg[KEY_W-1-ROT_AMT:0], key_reg[KEY_W-1 -: ROT_AMT]};

  sbox_4bit u_sbox (
    .din  (key_rot[KEY_W-1 -: 4]),
    .dout (sbox_out)
  );

  assign idx_inc = idx + IDX_W'(1);
  assign rc      = 4'(idx_inc);

  always_comb begin
    key_upd               = key_rot;
    key_upd[KEY_W-1 -: 4] = sbox_out;
    key_upd[3:0]          = key_rot[3:0] ^ rc;
  end

  // Handshake: a key transfers on a rising edge where valid && ready; while
  // valid && !ready the key, index and state are held unchanged.
  assign accept = (state == RUN) && valid_reg && io_rk_ready;

  always_comb begin
    state_n = state;
    key_n   = key_reg;
    idx_n   = idx;
    done_n  = 1'b0;
    if (io_clear) begin
      state_n = IDLE;
      idx_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (io_start) begin
            key_n   = io_master_key;
            idx_n   = '0;
            state_n = RUN;
          end
        end
        RUN: begin
          if (accept) begin
            if (idx == LAST_IDX) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              key_n = key_upd;
              idx_n = idx_inc;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      key_reg   <= '0;
      idx       <= '0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state     <= state_n;
      key_reg   <= key_n;
      idx       <= idx_n;
      valid_reg <= (state_n == RUN);
      busy_reg  <= (state_n == RUN);
      done_reg  <= done_n;
    end
  end

  assign io_round_key = key_reg[KEY_W-1 -: 4];
  assign io_round_idx = idx;
  assign io_rk_valid  = valid_reg;
  assign io_busy      = busy_reg;
  assign io_done      = done_reg;

endmodule

// File: tb/tb_key_schedule_4bit.sv
// Self-checking bench for key_schedule_4bit: hand-derived vector table plus
// randomized runs scored against an arithmetic reference of the key schedule.
module tb_key_schedule_4bit;

  localparam int KEY_W      = 16;
  localparam int NUM_ROUNDS = 15;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_start, io_clear, io_rk_ready;
  logic [15:0] io_master_key;
  logic [3:0]  io_round_key;
  logic        io_rk_valid, io_busy, io_done;
  logic [3:0]  io_round_idx;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];

  int sbox_ref [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

  typedef struct {
    logic [15:0] mk;
    int          r;
    logic [15:0] key;
    logic [3:0]  rk;
  } vec_t;
  vec_t vecs [5];

  key_schedule_4bit #(.KEY_W(KEY_W), .NUM_ROUNDS(NUM_ROUNDS)) dut (
    .clock         (clock),
    .reset         (reset),
    .io_start      (io_start),
    .io_clear      (io_clear),
    .io_master_key (io_master_key),
    .io_round_key  (io_round_key),
    .io_rk_valid   (io_rk_valid),
    .io_rk_ready   (io_rk_ready),
    .io_round_idx  (io_round_idx),
    .io_busy       (io_busy),
    .io_done       (io_done)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference round update using plain integer arithmetic.
  function automatic logic [15:0] model_step(input logic [15:0] k, input int i);
    int t;
    t = ((int'(k) * 8) + (int'(k) / 8192)) % 65536;
    t = sbox_ref[t / 4096] * 4096 + (t % 4096);
    t = t ^ (i % 16);
    return t[15:0];
  endfunction

  function automatic logic [15:0] model_key(input logic [15:0] mk, input int r);
    logic [15:0] k;
    k = mk;
    for (int j = 1; j <= r; j++) k = model_step(k, j);
    return k;
  endfunction

  // ready_mode: 0 = always ready, 1 = random ready, 2 = 5-cycle stall at idx 3.
  // stop_at >= 0 returns (still in RUN) once that index is presented.
  task automatic run_keys(input logic [15:0] mk, input int ready_mode,
                          input bit poke_start, input int stop_at);
    logic [23:0] obs, req, prev;
    logic [15:0] k;
    int          cycles, valid_cnt, stall_cnt;
    bit          rdy, held;
    exp_q.delete();
    k = mk;
    for (int r = 0; r <= NUM_ROUNDS; r++) begin
      if (r > 0) k = model_step(k, r);
      exp_q.push_back({4'(r), k[15:12], k});
    end
    io_master_key = mk;
    io_start      = 1'b1;
    io_rk_ready   = 1'b0;
    @(negedge clock);
    io_start = 1'b0;
    check("start_latency_valid", {31'd0, io_rk_valid}, 32'd1);
    cycles = 0; valid_cnt = 0; stall_cnt = 0; held = 1'b0; prev = '0;
    while (exp_q.size() > 0 && cycles < 300) begin
      obs = {io_round_idx, io_round_key, dut.key_reg};
      if (stop_at >= 0 && io_rk_valid && io_round_idx == 4'(stop_at)) begin
        io_rk_ready = 1'b0;
        return;
      end
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 3) != 0);
        default: begin
          rdy = !(io_round_idx == 4'd3 && stall_cnt < 5);
          if (!rdy) stall_cnt++;
        end
      endcase
      io_rk_ready = rdy;
      io_start    = poke_start ? ($urandom_range(0, 1) == 1) : 1'b0;
      if (io_rk_valid) begin
        valid_cnt++;
        if (held) check("hold_while_stalled", {8'd0, obs}, {8'd0, prev});
        if (rdy) begin
          req = exp_q.pop_front();
          check("round_key_idx_state", {8'd0, obs}, {8'd0, req});
          if (exp_q.size() == 0 && poke_start) io_start = 1'b1;
        end
        held = !rdy;
        prev = obs;
      end else begin
        check("valid_during_run", {31'd0, io_rk_valid}, 32'd1);
      end
      @(negedge clock);
      cycles++;
    end
    check("run_complete", exp_q.size(), 32'd0);
    io_start    = 1'b0;
    io_rk_ready = 1'b0;
    check("done_pulse", {31'd0, io_done}, 32'd1);
    check("valid_after_last", {31'd0, io_rk_valid}, 32'd0);
    check("busy_after_last", {31'd0, io_busy}, 32'd0);
    check("key_kept_after_last", {16'd0, dut.key_reg}, {16'd0, k});
    if (ready_mode == 0) check("valid_cycles", valid_cnt, 32'd16);
    if (ready_mode == 2) check("valid_cycles_stalled", valid_cnt, 32'd21);
    @(negedge clock);
    check("done_one_cycle", {31'd0, io_done}, 32'd0);
    check("idle_after_done", {31'd0, io_busy}, 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_round_key"}, {28'd0, io_round_key}, 32'd0);
    check({tag, "_valid"}, {31'd0, io_rk_valid}, 32'd0);
    check({tag, "_busy"}, {31'd0, io_busy}, 32'd0);
    check({tag, "_done"}, {31'd0, io_done}, 32'd0);
    check({tag, "_idx"}, {28'd0, io_round_idx}, 32'd0);
  endtask

  initial begin
    logic [15:0] mk;
    vecs[0] = '{16'h0000, 0, 16'h0000, 4'h0};
    vecs[1] = '{16'h0000, 1, 16'hC001, 4'hC};
    vecs[2] = '{16'h0000, 2, 16'hC00C, 4'hC};
    vecs[3] = '{16'hFFFF, 0, 16'hFFFF, 4'hF};
    vecs[4] = '{16'hFFFF, 1, 16'h2FFE, 4'h2};

    reset = 1'b0; io_start = 1'b0; io_clear = 1'b0;
    io_master_key = '0; io_rk_ready = 1'b0;
    repeat (2) @(negedge clock);
    check_zero_outputs("reset");
    check("reset_key_state", {16'd0, dut.key_reg}, 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // Hand-derived vectors: stop at index r and compare round key and key state.
    for (int v = 0; v < 5; v++) begin
      run_keys(vecs[v].mk, 0, 1'b0, vecs[v].r);
      check("vec_idx", {28'd0, io_round_idx}, 32'(vecs[v].r));
      check("vec_round_key", {28'd0, io_round_key}, {28'd0, vecs[v].rk});
      check("vec_key_state", {16'd0, dut.key_reg}, {16'd0, vecs[v].key});
      io_clear = 1'b1;
      @(negedge clock);
      io_clear = 1'b0;
    end

    // Full unstalled run, then the 5-cycle stall at idx 3 with the same key.
    mk = 16'($urandom);
    run_keys(mk, 0, 1'b0, -1);
    run_keys(mk, 2, 1'b0, -1);

    // Random ready with start poked during RUN and on the last accept.
    for (int n = 0; n < 4; n++) run_keys(16'($urandom), 1, 1'b1, -1);

    // Asynchronous reset at idx 7, then replay from idx 0.
    mk = 16'($urandom);
    run_keys(mk, 0, 1'b0, 7);
    #2 reset = 1'b0;
    #1 check_zero_outputs("async_reset");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("no_done_after_reset", {31'd0, io_done}, 32'd0);
    run_keys(mk, 0, 1'b0, -1);

    // Clear at idx 4 wins over start and ready; key state retained, no done.
    mk = 16'($urandom);
    run_keys(mk, 0, 1'b0, 4);
    io_clear = 1'b1; io_start = 1'b1; io_rk_ready = 1'b1;
    @(negedge clock);
    io_clear = 1'b0; io_start = 1'b0; io_rk_ready = 1'b0;
    check("clear_valid", {31'd0, io_rk_valid}, 32'd0);
    check("clear_busy", {31'd0, io_busy}, 32'd0);
    check("clear_idx", {28'd0, io_round_idx}, 32'd0);
    check("clear_no_done", {31'd0, io_done}, 32'd0);
    check("clear_key_kept", {16'd0, dut.key_reg}, {16'd0, model_key(mk, 4)});
    @(negedge clock);
    check("clear_no_late_done", {31'd0, io_done}, 32'd0);
    check("clear_stays_idle", {31'd0, io_busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
